// File: rtl/jk_mod_counter_pkg.sv
// Shared definitions for the JK-cell modulo counter: per-bit JK command
// encoding and the helper that picks a set/clear/hold command for one bit.
package jk_mod_counter_pkg;

    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_CLR  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_cmd_e;

    // Command that moves one bit from cur to nxt using only set/clear/hold.
    function automatic jk_cmd_e jk_cmd(input logic cur, input logic nxt);
        if (cur == nxt) return JK_HOLD;
        return nxt ? JK_SET : JK_CLR;
    endfunction

endpackage

// File: rtl/jk_ff_cell.sv
// Single posedge JK flip-flop with asynchronous active-low reset.
// q and qbar are separate registers so both are truly registered outputs.
module jk_ff_cell #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qbar
);

    // JK truth table; qbar is always updated to the complement of the new q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= RST_VAL;
            qbar <= ~RST_VAL;
        end else begin
            case ({j, k})
                2'b01:   begin q <= 1'b0; qbar <= 1'b1; end
                2'b10:   begin q <= 1'b1; qbar <= 1'b0; end
                2'b11:   begin q <= ~q;   qbar <= q;    end
                default: begin q <= q;    qbar <= qbar; end
            endcase
        end
    end

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo 0..MAX_COUNT up/down counter with parallel load, built from one
// JK cell per bit. Steps toggle along a carry/borrow chain; wrap and load
// drive each bit with set/clear.
// Build option: JK_MOD_COUNTER_SATURATE_EN makes counting hold at the
// terminal value instead of wrapping.
module jk_mod_counter
    import jk_mod_counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 9,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

    logic                  at_max;
    logic                  at_zero;
    logic [WIDTH-1:0]      ld_clamped;
    logic [WIDTH-1:0][1:0] cmd;

    assign at_max     = (q == MAX_Q);
    assign at_zero    = (q == '0);
    assign ld_clamped = (load_val > MAX_Q) ? MAX_Q : load_val;
    assign tc         = en & ~load & (up ? at_max : at_zero);

    // Per-bit JK commands: load > count > hold
    always_comb begin
        logic chain;
        cmd   = '0;
        chain = 1'b1;
        if (load) begin
            for (int i = 0; i < WIDTH; i++) cmd[i] = jk_cmd(q[i], ld_clamped[i]);
        end else if (en) begin
            if (up && at_max) begin
`ifdef JK_MOD_COUNTER_SATURATE_EN
                cmd = '0;
`else
                for (int i = 0; i < WIDTH; i++) cmd[i] = jk_cmd(q[i], 1'b0);
`endif
            end else if (!up && at_zero) begin
`ifdef JK_MOD_COUNTER_SATURATE_EN
                cmd = '0;
`else
                for (int i = 0; i < WIDTH; i++) cmd[i] = jk_cmd(q[i], MAX_Q[i]);
`endif
            end else begin
                // bit i toggles when all lower bits are 1 (up) or 0 (down)
                for (int i = 0; i < WIDTH; i++) begin
                    cmd[i] = chain ? JK_TGL : JK_HOLD;
                    chain  = chain & (up ? q[i] : ~q[i]);
                end
            end
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        jk_ff_cell #(.RST_VAL(RST_Q[g])) u_cell (
            .clk  (clk),
            .rst_n(rst_n),
            .j    (cmd[g][1]),
            .k    (cmd[g][0]),
            .q    (q[g]),
            .qbar (qbar[g])
        );
    end

endmodule
